regbank_arbiter: RTL and testbench

- Shares the single register bank (two read ports, one write port, registered read data) between two requesters: the processor core datapath and a debug/loader port.
- Sits between both requesters and the bank, and drives all bank address, write-enable and write-data inputs.
- Core has fixed priority. A starvation counter guarantees the debug port a grant within a bounded number of cycles.

---
 rtl/regbank_arbiter.sv | 162 ++++++++++++++++
 tb/tb_regbank_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regbank_arbiter.sv
// rtl/regbank_arbiter.sv - fixed-priority register bank arbiter with debug starvation guard
//
// Purpose:
//   Shares one register bank (two read ports, one write port, registered read
//   data) between the core datapath and a debug/loader port. The core wins
//   every contended cycle unless debug has been denied MAX_WAIT cycles in a
//   row, in which case debug is forced through.
//
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-low reset
//   core_req/we/ra1/ra2/wa/wd core request, write enable, addresses, write data
//   core_gnt, core_stall     core grant (combinational), core_req & ~core_gnt
//   core_rvalid/rd1/rd2      core read return, one cycle after a core grant
//   dbg_req/we/addr/wd       debug request, write enable, address, write data
//   dbg_gnt                  debug grant (combinational)
//   dbg_rvalid/rd            debug read return, one cycle after a debug read grant
//   bk_ra1/ra2/wa/we/wd      bank address, write-enable and write-data drive
//   bk_rd1/rd2               bank registered read data

module regbank_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int DW       = 32,
    parameter int AW       = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_ra1,
    input  logic [AW-1:0] core_ra2,
    input  logic [AW-1:0] core_wa,
    input  logic [DW-1:0] core_wd,
    output logic          core_gnt,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rd1,
    output logic [DW-1:0] core_rd2,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wd,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rd,
    output logic [AW-1:0] bk_ra1,
    output logic [AW-1:0] bk_ra2,
    output logic [AW-1:0] bk_wa,
    output logic          bk_we,
    output logic [DW-1:0] bk_wd,
    input  logic [DW-1:0] bk_rd1,
    input  logic [DW-1:0] bk_rd2
);

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_CORE   = 2'd1,
        OWN_DBG_RD = 2'd2
    } owner_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0]    wait_cnt;
    logic          force_dbg;
    owner_t        owner;
    owner_t        owner_nxt;
    logic [DW-1:0] core_rd1_q;
    logic [DW-1:0] core_rd2_q;
    logic [DW-1:0] dbg_rd_q;
    logic          sel_we;

    // Arbitration. Grants are gated by reset so nothing reaches the bank
    // while the block is held in reset.
    assign force_dbg  = (wait_cnt == WAIT_MAX);
    assign dbg_gnt    = reset & dbg_req & (~core_req | force_dbg);
    assign core_gnt   = reset & core_req & ~dbg_gnt;
    assign core_stall = core_req & ~core_gnt;

    // Bank drive mux; idle cycles present all-zero addresses and data.
    always_comb begin
        bk_ra1 = '0;
        bk_ra2 = '0;
        bk_wa  = '0;
        bk_wd  = '0;
        sel_we = 1'b0;
        if (core_gnt) begin
            bk_ra1 = core_ra1;
            bk_ra2 = core_ra2;
            bk_wa  = core_wa;
            bk_wd  = core_wd;
            sel_we = core_we;
        end else if (dbg_gnt) begin
            bk_ra1 = dbg_addr;
            bk_ra2 = dbg_addr;
            bk_wa  = dbg_addr;
            bk_wd  = dbg_wd;
            sel_we = dbg_we;
        end
    end

    // r0 is hardwired zero: suppress any write that targets it.
    assign bk_we = sel_we & (bk_wa != '0);

    // Starvation counter: counts consecutive denied debug cycles, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 4'd0;
        end else if (dbg_gnt || !dbg_req) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Owner tracks who gets the read data the bank returns next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_nxt;
        end
    end

    always_comb begin
        owner_nxt   = OWN_NONE;
        core_rvalid = 1'b0;
        dbg_rvalid  = 1'b0;
        if (core_gnt) begin
            owner_nxt = OWN_CORE;
        end else if (dbg_gnt && !dbg_we) begin
            owner_nxt = OWN_DBG_RD;
        end
        if (owner == OWN_CORE) begin
            core_rvalid = 1'b1;
        end
        if (owner == OWN_DBG_RD) begin
            dbg_rvalid = 1'b1;
        end
    end

    // Hold registers keep the last returned data visible between pulses;
    // during the valid cycle the bank data is passed straight through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_rd1_q <= '0;
            core_rd2_q <= '0;
            dbg_rd_q   <= '0;
        end else begin
            if (core_rvalid) begin
                core_rd1_q <= bk_rd1;
                core_rd2_q <= bk_rd2;
            end
            if (dbg_rvalid) begin
                dbg_rd_q <= bk_rd1;
            end
        end
    end

    assign core_rd1 = core_rvalid ? bk_rd1 : core_rd1_q;
    assign core_rd2 = core_rvalid ? bk_rd2 : core_rd2_q;
    assign dbg_rd   = dbg_rvalid  ? bk_rd1 : dbg_rd_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// tb/tb_regbank_arbiter.sv - directed vector bench for regbank_arbiter

module tb_regbank_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          core_req, core_we;
    logic [AW-1:0] core_ra1, core_ra2, core_wa;
    logic [DW-1:0] core_wd;
    logic          core_gnt, core_stall, core_rvalid;
    logic [DW-1:0] core_rd1, core_rd2;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wd;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rd;
    logic [AW-1:0] bk_ra1, bk_ra2, bk_wa;
    logic          bk_we;
    logic [DW-1:0] bk_wd;
    logic [DW-1:0] bk_rd1 = '0;
    logic [DW-1:0] bk_rd2 = '0;

    logic [DW-1:0] mem [32];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regbank_arbiter #(.MAX_WAIT(4), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_ra1(core_ra1), .core_ra2(core_ra2),
        .core_wa(core_wa), .core_wd(core_wd),
        .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid),
        .core_rd1(core_rd1), .core_rd2(core_rd2),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wd(dbg_wd),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rd(dbg_rd),
        .bk_ra1(bk_ra1), .bk_ra2(bk_ra2), .bk_wa(bk_wa), .bk_we(bk_we), .bk_wd(bk_wd),
        .bk_rd1(bk_rd1), .bk_rd2(bk_rd2)
    );

    // Register bank: synchronous write, registered read of the pre-write value.
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
    end

    always @(posedge clk) begin
        bk_rd1 <= mem[bk_ra1];
        bk_rd2 <= mem[bk_ra2];
        if (bk_we) mem[bk_wa] <= bk_wd;
    end

    typedef struct packed {
        logic          creq;
        logic          cwe;
        logic [AW-1:0] cra1;
        logic [AW-1:0] cra2;
        logic [AW-1:0] cwa;
        logic [DW-1:0] cwd;
        logic          dreq;
        logic          dwe;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwd;
        logic          e_cg;
        logic          e_dg;
        logic          e_cs;
        logic          e_bkwe;
        logic          e_crv;
        logic [DW-1:0] e_crd1;
        logic [DW-1:0] e_crd2;
        logic          e_drv;
        logic [DW-1:0] e_drd;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic creq, input logic cwe, input logic [AW-1:0] cra1,
                          input logic [AW-1:0] cra2, input logic [AW-1:0] cwa,
                          input logic [DW-1:0] cwd, input logic dreq, input logic dwe,
                          input logic [AW-1:0] daddr, input logic [DW-1:0] dwd);
        core_req = creq; core_we = cwe; core_ra1 = cra1; core_ra2 = cra2;
        core_wa = cwa; core_wd = cwd;
        dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wd = dwd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic contend();
        set_in(1, 0, 5'd3, 5'd0, 5'd0, 32'h0, 1, 0, 5'd7, 32'h0);
    endtask

    localparam logic [31:0] A5 = 32'hA5A5A5A5;

    initial begin
        //          creq cwe cra1  cra2  cwa   cwd        dreq dwe daddr dwd      cg dg cs we crv crd1      crd2      drv drd
        vecs[0]  = '{0,  0,  5'd0, 5'd0, 5'd0, 32'h0,     0,   0,  5'd0, 32'h0,   0, 0, 0, 0, 0,  32'h0,    32'h0,    0,  32'h0};
        vecs[1]  = '{1,  1,  5'd0, 5'd0, 5'd3, 32'h55,    0,   0,  5'd0, 32'h0,   1, 0, 0, 1, 0,  32'h0,    32'h0,    0,  32'h0};
        vecs[2]  = '{1,  0,  5'd3, 5'd0, 5'd0, 32'h0,     0,   0,  5'd0, 32'h0,   1, 0, 0, 0, 1,  32'h0,    32'h0,    0,  32'h0};
        vecs[3]  = '{0,  0,  5'd0, 5'd0, 5'd0, 32'h0,     0,   0,  5'd0, 32'h0,   0, 0, 0, 0, 1,  32'h55,   32'h0,    0,  32'h0};
        vecs[4]  = '{0,  0,  5'd0, 5'd0, 5'd0, 32'h0,     1,   1,  5'd7, A5,      0, 1, 0, 1, 0,  32'h55,   32'h0,    0,  32'h0};
        vecs[5]  = '{0,  0,  5'd0, 5'd0, 5'd0, 32'h0,     1,   0,  5'd7, 32'h0,   0, 1, 0, 0, 0,  32'h55,   32'h0,    0,  32'h0};
        vecs[6]  = '{0,  0,  5'd0, 5'd0, 5'd0, 32'h0,     0,   0,  5'd0, 32'h0,   0, 0, 0, 0, 0,  32'h55,   32'h0,    1,  A5};
        vecs[7]  = '{1,  1,  5'd0, 5'd0, 5'd0, 32'hFFFF,  0,   0,  5'd0, 32'h0,   1, 0, 0, 0, 0,  32'h55,   32'h0,    0,  A5};
        vecs[8]  = '{1,  0,  5'd0, 5'd3, 5'd0, 32'h0,     0,   0,  5'd0, 32'h0,   1, 0, 0, 0, 1,  32'h0,    32'h0,    0,  A5};
        vecs[9]  = '{0,  0,  5'd0, 5'd0, 5'd0, 32'h0,     0,   0,  5'd0, 32'h0,   0, 0, 0, 0, 1,  32'h0,    32'h55,   0,  A5};
        vecs[10] = '{1,  1,  5'd5, 5'd5, 5'd5, 32'h77,    0,   0,  5'd0, 32'h0,   1, 0, 0, 1, 0,  32'h0,    32'h55,   0,  A5};
        vecs[11] = '{0,  0,  5'd0, 5'd0, 5'd0, 32'h0,     0,   0,  5'd0, 32'h0,   0, 0, 0, 0, 1,  32'h0,    32'h0,    0,  A5};
        vecs[12] = '{1,  0,  5'd5, 5'd3, 5'd0, 32'h0,     0,   0,  5'd0, 32'h0,   1, 0, 0, 0, 0,  32'h0,    32'h0,    0,  A5};
        vecs[13] = '{0,  0,  5'd0, 5'd0, 5'd0, 32'h0,     0,   0,  5'd0, 32'h0,   0, 0, 0, 0, 1,  32'h77,   32'h55,   0,  A5};

        set_in(0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i].creq, vecs[i].cwe, vecs[i].cra1, vecs[i].cra2, vecs[i].cwa,
                   vecs[i].cwd, vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwd);
            @(negedge clk);
            chk($sformatf("v%0d core_gnt", i),    32'(core_gnt),    32'(vecs[i].e_cg));
            chk($sformatf("v%0d dbg_gnt", i),     32'(dbg_gnt),     32'(vecs[i].e_dg));
            chk($sformatf("v%0d core_stall", i),  32'(core_stall),  32'(vecs[i].e_cs));
            chk($sformatf("v%0d bk_we", i),       32'(bk_we),       32'(vecs[i].e_bkwe));
            chk($sformatf("v%0d core_rvalid", i), 32'(core_rvalid), 32'(vecs[i].e_crv));
            chk($sformatf("v%0d core_rd1", i),    core_rd1,         vecs[i].e_crd1);
            chk($sformatf("v%0d core_rd2", i),    core_rd2,         vecs[i].e_crd2);
            chk($sformatf("v%0d dbg_rvalid", i),  32'(dbg_rvalid),  32'(vecs[i].e_drv));
            chk($sformatf("v%0d dbg_rd", i),      dbg_rd,           vecs[i].e_drd);
            step();
        end

        // Continuous contention: core four cycles, then forced debug, period 5.
        for (int k = 0; k < 10; k++) begin
            contend();
            @(negedge clk);
            chk($sformatf("cont%0d core_gnt", k),   32'(core_gnt),   32'((k % 5) != 4));
            chk($sformatf("cont%0d dbg_gnt", k),    32'(dbg_gnt),    32'((k % 5) == 4));
            chk($sformatf("cont%0d core_stall", k), 32'(core_stall), 32'((k % 5) == 4));
            chk($sformatf("cont%0d dbg_rvalid", k), 32'(dbg_rvalid), 32'((k % 5) == 0 && k > 0));
            if (dbg_rvalid) chk($sformatf("cont%0d dbg_rd", k), dbg_rd, A5);
            step();
        end

        // Dropping dbg_req clears the starvation count.
        for (int k = 0; k < 8; k++) begin
            contend();
            if (k == 2) dbg_req = 1'b0;
            @(negedge clk);
            chk($sformatf("clr%0d dbg_gnt", k), 32'(dbg_gnt), 32'(k == 7));
            step();
        end

        // Build the count up to MAX_WAIT, then reset while debug is forced through.
        for (int k = 0; k < 4; k++) begin
            contend();
            @(negedge clk);
            chk($sformatf("pre%0d core_gnt", k), 32'(core_gnt), 32'h1);
            step();
        end
        contend();
        #2;
        chk("rst forced dbg_gnt", 32'(dbg_gnt), 32'h1);
        reset = 1'b0;
        #1;
        chk("rst dbg_gnt", 32'(dbg_gnt), 32'h0);
        chk("rst core_gnt", 32'(core_gnt), 32'h0);
        step();
        set_in(1, 1, 5'd0, 5'd0, 5'd9, 32'h99, 0, 0, 5'd0, 32'h0);
        @(negedge clk);
        chk("rst bk_we", 32'(bk_we), 32'h0);
        chk("rst core_gnt w", 32'(core_gnt), 32'h0);
        chk("rst dbg_rvalid", 32'(dbg_rvalid), 32'h0);
        step();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            contend();
            @(negedge clk);
            chk($sformatf("post%0d core_gnt", k), 32'(core_gnt), 32'(k != 4));
            chk($sformatf("post%0d dbg_gnt", k),  32'(dbg_gnt),  32'(k == 4));
            if (k == 0) begin
                chk("post dbg_rvalid", 32'(dbg_rvalid), 32'h0);
                chk("post dbg_rd", dbg_rd, 32'h0);
                chk("post core_rd1", core_rd1, 32'h0);
            end
            step();
        end

        // r9 must not have been written while reset was low.
        set_in(1, 0, 5'd9, 5'd7, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        step();
        set_in(0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        @(negedge clk);
        chk("r9 core_rvalid", 32'(core_rvalid), 32'h1);
        chk("r9 core_rd1", core_rd1, 32'h0);
        chk("r7 core_rd2", core_rd2, A5);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
